mdu_seq_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in XLEN. It is the sequential companion to the core's combinational ALU control decode.
- It decodes op/funct3/funct7 for the M extension and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles with a start/busy/done handshake.
- It sits beside the ALU in the execute stage. The core stalls on busy and muxes result into writeback on done.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_sign_fix.sv | 14 +
 rtl/mdu_seq_unit.sv | 136 +++++++++++++
 tb/tb_mdu_seq_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M sequential multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result correction.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  always_comb begin
    val_o = neg_i ? (~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/mdu_seq_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle on magnitudes, sign-corrected at the end.
module mdu_seq_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [6:0]      op_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_m_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        f3_q;
  logic              neg1_q, neg2_q, done_q;
  logic [XLEN-1:0]   a_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              accept, s1_signed, s2_signed, neg1, neg2, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, special_res, div_sel, div_fix, final_res;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic              div_neg;

  always_comb begin
    is_m_o    = (op_i == OPC_OP) && (funct7_i == F7_MULDIV);
    accept    = start_i && is_m_o && (state_q != StCalc) && !flush_i;
    busy_o    = (state_q == StCalc) || accept;
    s1_signed = (funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    s2_signed = (funct3_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
    neg1      = s1_signed && rs1_i[XLEN-1];
    neg2      = s2_signed && rs2_i[XLEN-1];
    is_div    = funct3_i[2];
    div_zero  = is_div && (rs2_i == '0);
    div_ovf   = is_div && !funct3_i[0] && (rs1_i == MinNeg) && (rs2_i == '1);
    // Divide-by-zero takes precedence; REM variants return the dividend / zero.
    if (div_zero)     special_res = funct3_i[1] ? rs1_i : '1;
    else              special_res = funct3_i[1] ? '0 : MinNeg;
  end

  mdu_sign_fix #(.W(XLEN)) u_mag1 (.val_i(rs1_i), .neg_i(neg1), .val_o(mag1));
  mdu_sign_fix #(.W(XLEN)) u_mag2 (.val_i(rs2_i), .neg_i(neg2), .val_o(mag2));

  // Multiply: upper half accumulates, multiplier shifts out of the lower half.
  // Divide: upper half is the partial remainder, lower half shifts dividend in / quotient out.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = rem_sh - {1'b0, a_q};
    if (!diff[XLEN]) div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else             div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    acc_d    = f3_q[2] ? div_next : mul_next;
    div_sel  = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    div_neg  = f3_q[1] ? neg1_q : (neg1_q ^ neg2_q);
  end

  mdu_sign_fix #(.W(2*XLEN)) u_prod_fix (
    .val_i(mul_next), .neg_i(neg1_q ^ neg2_q), .val_o(prod_fix)
  );
  mdu_sign_fix #(.W(XLEN)) u_div_fix (.val_i(div_sel), .neg_i(div_neg), .val_o(div_fix));

  always_comb begin
    if (f3_q[2])              final_res = div_fix;
    else if (f3_q == F3_MUL)  final_res = prod_fix[XLEN-1:0];
    else                      final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      f3_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            f3_q   <= funct3_i;
            neg1_q <= neg1;
            neg2_q <= neg2;
            a_q    <= is_div ? mag2 : mag1;
            acc_q  <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            cnt_q  <= CntW'(XLEN - 1);
            if (div_zero || div_ovf) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= StCalc;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= final_res;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Directed bench for mdu_seq_unit at XLEN=32 and XLEN=8.
module tb_mdu_seq_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, start8, flush;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2, result;
  logic [7:0]  a8, b8, result8;
  logic        is_m, busy, done, is_m8, busy8, done8;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mdu_seq_unit #(.XLEN(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush), .op_i(op),
    .funct3_i(f3), .funct7_i(f7), .rs1_i(rs1), .rs2_i(rs2),
    .is_m_o(is_m), .busy_o(busy), .done_o(done), .result_o(result)
  );

  mdu_seq_unit #(.XLEN(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .flush_i(flush), .op_i(op),
    .funct3_i(f3), .funct7_i(f7), .rs1_i(a8), .rs2_i(b8),
    .is_m_o(is_m8), .busy_o(busy8), .done_o(done8), .result_o(result8)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse start for one op and count edges after the accept edge until done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op = OPC_OP; f7 = F7_MULDIV; f3 = f; rs1 = a; rs2 = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin step(); lat++; end
    res = result;
  endtask

  task automatic run_op8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output int lat);
    op = OPC_OP; f7 = F7_MULDIV; f3 = f; a8 = a; b8 = b; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 200) begin step(); lat++; end
    res = result8;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0; flush = 1'b0;
    op = OPC_OP; f7 = F7_MULDIV; f3 = F3_MUL; rs1 = '0; rs2 = '0; a8 = '0; b8 = '0;
    step(); step();
    rst = 1'b0;
    n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    #1;
    n_vec++; if (is_m !== 1'b1) begin n_err++; $display("FAIL is_m_mext got %b want 1", is_m); end
    f7 = 7'b0100000; #1;
    n_vec++; if (is_m !== 1'b0) begin n_err++; $display("FAIL is_m_f7 got %b want 0", is_m); end
    op = 7'b0010011; f7 = F7_MULDIV; #1;
    n_vec++; if (is_m !== 1'b0) begin n_err++; $display("FAIL is_m_op got %b want 0", is_m); end
  endtask

  task automatic test_mul();
    logic [2:0]  fv [4] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU};
    logic [31:0] av [4] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2};
    logic [31:0] ev [4] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], r, lat);
      n_vec++; if (r !== ev[i]) begin n_err++; $display("FAIL mul_result[%0d] got %h want %h", i, r, ev[i]); end
      n_vec++; if (lat != 32) begin n_err++; $display("FAIL mul_latency[%0d] got %0d want 32", i, lat); end
      step();
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mul_done_width[%0d] got %b want 0", i, done); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fv [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [31:0] av [4] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'h80000000, 32'd100};
    logic [31:0] bv [4] = '{32'd3, 32'd3, 32'd2, 32'd7};
    logic [31:0] ev [4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'h40000000, 32'd2};
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], r, lat);
      n_vec++; if (r !== ev[i]) begin n_err++; $display("FAIL div_result[%0d] got %h want %h", i, r, ev[i]); end
      n_vec++; if (lat != 32) begin n_err++; $display("FAIL div_latency[%0d] got %0d want 32", i, lat); end
      step();
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [4] = '{F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] av [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(fv[i], av[i], bv[i], r, lat);
      n_vec++; if (r !== ev[i]) begin n_err++; $display("FAIL special_result[%0d] got %h want %h", i, r, ev[i]); end
      n_vec++; if (lat != 0) begin n_err++; $display("FAIL special_latency[%0d] got %0d want 0", i, lat); end
      step();
      n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL special_after[%0d] busy,done got %b want 00", i, {busy, done}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int          lat;
    run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, r, lat);
    n_vec++; if (r !== 32'hFFFFFFEB) begin n_err++; $display("FAIL b2b_first got %h want ffffffeb", r); end
    f3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_accept got %b want 1", busy); end
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin step(); lat++; end
    n_vec++; if (lat != 32) begin n_err++; $display("FAIL b2b_spacing got %0d want 32", lat); end
    n_vec++; if (result !== 32'd14) begin n_err++; $display("FAIL b2b_second got %h want 0000000e", result); end
    step();
  endtask

  task automatic test_not_m();
    logic seen;
    seen = 1'b0;
    op = OPC_OP; f7 = 7'b0000000; f3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd4; start = 1'b1; #1;
    n_vec++; if ({is_m, busy} !== 2'b00) begin n_err++; $display("FAIL not_m_is_m_busy got %b want 00", {is_m, busy}); end
    for (int i = 0; i < 40; i++) begin step(); if (done || busy) seen = 1'b1; end
    start = 1'b0;
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL not_m_activity got %b want 0", seen); end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [31:0] prior, r;
    logic        seen;
    int          lat;
    prior = result;
    seen  = 1'b0;
    op = OPC_OP; f7 = F7_MULDIV; f3 = F3_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort%0d_idle busy,done got %b want 00", use_rst, {busy, done}); end
    for (int i = 0; i < 40; i++) begin step(); if (done) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort%0d_no_done got %b want 0", use_rst, seen); end
    if (use_rst) begin
      n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_result got %h want 0", result); end
    end else begin
      n_vec++; if (result !== prior) begin n_err++; $display("FAIL flush_result got %h want %h", result, prior); end
    end
    run_op(F3_REMU, 32'd100, 32'd7, r, lat);
    n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL abort%0d_next got %h want 2", use_rst, r); end
    n_vec++; if (lat != 32) begin n_err++; $display("FAIL abort%0d_next_lat got %0d want 32", use_rst, lat); end
    step();
  endtask

  task automatic test_xlen8();
    logic [2:0] fv [4] = '{F3_MUL, F3_MULHU, F3_DIV, F3_DIVU};
    logic [7:0] av [4] = '{8'h10, 8'h10, 8'h80, 8'hC8};
    logic [7:0] bv [4] = '{8'h10, 8'h10, 8'hFF, 8'h0A};
    logic [7:0] ev [4] = '{8'h00, 8'h01, 8'h80, 8'h14};
    int         lv [4] = '{8, 8, 0, 8};
    logic [7:0] r;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      run_op8(fv[i], av[i], bv[i], r, lat);
      n_vec++; if (r !== ev[i]) begin n_err++; $display("FAIL x8_result[%0d] got %h want %h", i, r, ev[i]); end
      n_vec++; if (lat != lv[i]) begin n_err++; $display("FAIL x8_latency[%0d] got %0d want %0d", i, lat, lv[i]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_not_m();
    test_abort(1'b0);
    test_abort(1'b1);
    test_xlen8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
